keypad_scan_debounce: RTL and testbench

//  Scans a 4x4 matrix keypad and debounces it. Produces a stable 16-bit key

---
 rtl/keypad_scan_debounce.sv | 168 ++++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_debounce.sv
// -----------------------------------------------------------------------------
// keypad_scan_debounce
//
// Scans a 4x4 matrix keypad one column at a time and debounces the result.
// A new 16-bit key vector is committed only after DEBOUNCE_SCANS consecutive
// identical full scans. The committed vector feeds the 16-to-4 encoder /
// seven-segment path.
//
// Ports
//   clock      in   1   system clock, rising edge
//   reset      in   1   asynchronous, active-high; clears all state
//   row        in   4   keypad rows, active-low (0 = key on driven column closed)
//   col        out  4   column drive, active-low, exactly one bit low
//   keys       out  16  debounced key vector, bit = row*4 + col, 1 = pressed
//   key_press  out  1   one-cycle pulse when a commit adds a newly pressed key
//   multi_key  out  1   level, committed vector has more than one key set
//
// Parameters
//   SCAN_DIV        clocks per column dwell (>= 4)
//   DEBOUNCE_SCANS  identical full scans required to commit (>= 2)
// -----------------------------------------------------------------------------
module keypad_scan_debounce #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [15:0] keys,
   output logic        key_press,
   output logic        multi_key
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int RW = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [RW-1:0] RUN_MAX   = RW'(DEBOUNCE_SCANS);

   // True when more than one bit of the vector is set (clearing the lowest
   // set bit leaves something behind).
   function automatic logic more_than_one(input logic [15:0] v);
      more_than_one = ((v & (v - 16'd1)) != 16'd0);
   endfunction

   // Registers and their next-state values
   logic [3:0]    row_meta_q, row_sync_q;
   logic [PW-1:0] presc_q,    presc_d;
   logic [1:0]    col_idx_q,  col_idx_d;
   logic [3:0]    col_q,      col_d;
   logic [15:0]   scan_q,     scan_d;
   logic [15:0]   prev_q,     prev_d;
   logic [RW-1:0] run_q,      run_d;
   logic [15:0]   keys_q,     keys_d;
   logic          press_q,    press_d;
   logic          multi_q,    multi_d;

   // Combinational helpers
   logic          tick_s;
   logic [3:0]    col_onehot_s;
   logic [15:0]   col_mask_s;
   logic [15:0]   row_bits_s;
   logic [15:0]   scan_full_s;
   logic [RW-1:0] run_next_s;

   // Sample window position, and the scan vector with the current column's
   // rows merged in (this is what gets stored on tick; at c==3 it is the
   // complete scan being evaluated).
   always_comb begin
      tick_s       = (presc_q == PRESC_MAX);
      col_onehot_s = 4'b0001 << col_idx_q;
      col_mask_s   = {4{col_onehot_s}};
      // Each row's pressed state replicated across its 4-bit group; the
      // column mask then selects only the bit of the driven column.
      row_bits_s   = {{4{~row_sync_q[3]}}, {4{~row_sync_q[2]}},
                      {4{~row_sync_q[1]}}, {4{~row_sync_q[0]}}};
      scan_full_s  = (scan_q & ~col_mask_s) | (row_bits_s & col_mask_s);
      if (scan_full_s == prev_q) begin
         if (run_q == RUN_MAX) begin
            run_next_s = RUN_MAX;
         end else begin
            run_next_s = run_q + RW'(1);
         end
      end else begin
         run_next_s = RW'(1);
      end
   end

   // Next-state logic for scanning, debounce run and committed outputs.
   always_comb begin
      presc_d   = presc_q;
      col_idx_d = col_idx_q;
      col_d     = col_q;
      scan_d    = scan_q;
      prev_d    = prev_q;
      run_d     = run_q;
      keys_d    = keys_q;
      press_d   = 1'b0;
      multi_d   = multi_q;

      if (tick_s) begin
         presc_d   = {PW{1'b0}};
         col_idx_d = col_idx_q + 2'd1;
         col_d     = ~(4'b0001 << col_idx_d);
         scan_d    = scan_full_s;
         if (col_idx_q == 2'd3) begin
            prev_d = scan_full_s;
            run_d  = run_next_s;
            // Commit only on reaching the required run with a changed
            // vector; identical commits produce no output activity.
            if ((run_next_s == RUN_MAX) && (scan_full_s != keys_q)) begin
               keys_d  = scan_full_s;
               press_d = |(scan_full_s & ~keys_q);
               multi_d = more_than_one(scan_full_s);
            end else begin
               keys_d  = keys_q;
            end
         end else begin
            prev_d = prev_q;
         end
      end else begin
         presc_d = presc_q + PW'(1);
      end
   end

   // Row synchronizer; idles high so an open keypad reads as no keys.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         row_meta_q <= 4'b1111;
         row_sync_q <= 4'b1111;
      end else begin
         row_meta_q <= row;
         row_sync_q <= row_meta_q;
      end
   end

   // Scan, debounce and output state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc_q   <= {PW{1'b0}};
         col_idx_q <= 2'd0;
         col_q     <= 4'b1110;
         scan_q    <= 16'h0000;
         prev_q    <= 16'h0000;
         run_q     <= {RW{1'b0}};
         keys_q    <= 16'h0000;
         press_q   <= 1'b0;
         multi_q   <= 1'b0;
      end else begin
         presc_q   <= presc_d;
         col_idx_q <= col_idx_d;
         col_q     <= col_d;
         scan_q    <= scan_d;
         prev_q    <= prev_d;
         run_q     <= run_d;
         keys_q    <= keys_d;
         press_q   <= press_d;
         multi_q   <= multi_d;
      end
   end

   assign col       = col_q;
   assign keys      = keys_q;
   assign key_press = press_q;
   assign multi_key = multi_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// -----------------------------------------------------------------------------
// tb_keypad_scan_debounce
//
// Directed bench for keypad_scan_debounce with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// A keypad model pulls row r low while column c is driven low and key
// r*4+c is held in key_mask.
// -----------------------------------------------------------------------------
module tb_keypad_scan_debounce;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [15:0] keys;
   logic        key_press;
   logic        multi_key;

   logic [15:0] key_mask = 16'h0000;
   int          n_vec     = 0;
   int          n_err     = 0;
   int          pulse_cnt = 0;
   int          base;

   keypad_scan_debounce #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (3)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .keys      (keys),
      .key_press (key_press),
      .multi_key (multi_key)
   );

   always #5 clock = ~clock;

   // Keypad matrix model
   assign row[0] = ~|(key_mask[3:0]   & ~col);
   assign row[1] = ~|(key_mask[7:4]   & ~col);
   assign row[2] = ~|(key_mask[11:8]  & ~col);
   assign row[3] = ~|(key_mask[15:12] & ~col);

   // Count clock cycles with key_press high (a 2-cycle pulse counts twice)
   always @(negedge clock) begin
      if (key_press) pulse_cnt++;
   end

   task automatic check_vec(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Wait up to budget clocks for keys to reach exp, then compare
   task automatic wait_keys(input string tag, input logic [15:0] exp,
                            input int budget);
      int i;
      i = 0;
      while ((i < budget) && (keys !== exp)) begin
         @(posedge clock); #1;
         i++;
      end
      check_vec(tag, {16'h0, keys}, {16'h0, exp});
   endtask

   initial begin
      logic [3:0] exp_col;

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      check_vec("rst_col",   {28'h0, col},       32'he);
      check_vec("rst_keys",  {16'h0, keys},      32'h0);
      check_vec("rst_press", {31'h0, key_press}, 32'h0);
      check_vec("rst_multi", {31'h0, multi_key}, 32'h0);
      @(negedge clock);
      reset = 1'b0;

      // 1. Idle column sequence, 4 clocks per column
      for (int k = 1; k <= 16; k++) begin
         @(posedge clock); #1;
         exp_col = ~(4'b0001 << ((k / 4) % 4));
         check_vec("idle_col", {28'h0, col}, {28'h0, exp_col});
      end
      repeat (48) @(posedge clock);
      #1;
      check_vec("idle_keys",  {16'h0, keys}, 32'h0);
      check_vec("idle_pulse", pulse_cnt,     0);

      // 2. Steady press of row1/col2 -> bit 6
      base     = pulse_cnt;
      key_mask = 16'h0040;
      wait_keys("press_keys", 16'h0040, 67);
      repeat (4) @(posedge clock);
      #1;
      check_vec("press_pulse", pulse_cnt - base,   1);
      check_vec("press_multi", {31'h0, multi_key}, 32'h0);

      // 4. Release
      base     = pulse_cnt;
      key_mask = 16'h0000;
      wait_keys("rel_keys", 16'h0000, 67);
      repeat (4) @(posedge clock);
      #1;
      check_vec("rel_pulse", pulse_cnt - base, 0);

      // 3. Bounce: toggle every 5 clocks for 80 clocks, then open
      base = pulse_cnt;
      for (int i = 0; i < 16; i++) begin
         key_mask = (i % 2 == 0) ? 16'h0040 : 16'h0000;
         repeat (5) @(posedge clock);
      end
      key_mask = 16'h0000;
      repeat (70) @(posedge clock);
      #1;
      check_vec("bounce_keys",  {16'h0, keys},   32'h0);
      check_vec("bounce_pulse", pulse_cnt - base, 0);

      // 5. Keys 0 and 15 together, then add key 5
      base     = pulse_cnt;
      key_mask = 16'h8001;
      wait_keys("two_keys", 16'h8001, 67);
      repeat (4) @(posedge clock);
      #1;
      check_vec("two_multi", {31'h0, multi_key}, 32'h1);
      check_vec("two_pulse", pulse_cnt - base,   1);
      base     = pulse_cnt;
      key_mask = 16'h8021;
      wait_keys("three_keys", 16'h8021, 67);
      repeat (4) @(posedge clock);
      #1;
      check_vec("three_multi", {31'h0, multi_key}, 32'h1);
      check_vec("three_pulse", pulse_cnt - base,   1);

      // 6. Reset mid-debounce
      key_mask = 16'h0000;
      wait_keys("pre6_keys", 16'h0000, 67);
      key_mask = 16'h0040;
      repeat (40) @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check_vec("mid_rst_keys",  {16'h0, keys},      32'h0);
      check_vec("mid_rst_col",   {28'h0, col},       32'he);
      check_vec("mid_rst_press", {31'h0, key_press}, 32'h0);
      base = pulse_cnt;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check_vec("rst_no_pulse", pulse_cnt - base, 0);
      base = pulse_cnt;
      wait_keys("post_rst_keys", 16'h0040, 67);
      repeat (4) @(posedge clock);
      #1;
      check_vec("post_rst_pulse", pulse_cnt - base,   1);
      check_vec("post_rst_multi", {31'h0, multi_key}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
